// File: rtl/lighting_pkg.sv
// Shared constants for the lighting controller input path.
// The lighting top level uses the same defaults.
package lighting_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF   = 16;
    localparam int unsigned PIR_FILTER_CYCLES_DEF = 4;
    localparam int unsigned LONG_PRESS_CYCLES_DEF = 1000;

    // Bits needed for a counter that can hold the value n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Raw pins in, conditioned levels and event pulses out.
// The slave side is the conditioner; the master side is whoever drives the pins.
interface input_conditioner_if;

    logic push_button;
    logic infravermelho;
    logic btn_level;
    logic btn_press;
    logic btn_long;
    logic motion;
    logic motion_rise;

    modport master (
        output push_button,
        output infravermelho,
        input  btn_level,
        input  btn_press,
        input  btn_long,
        input  motion,
        input  motion_rise
    );

    modport slave (
        input  push_button,
        input  infravermelho,
        output btn_level,
        output btn_press,
        output btn_long,
        output motion,
        output motion_rise
    );

endinterface

// File: rtl/input_conditioner_debounce_filter.sv
// Two-flop synchroniser plus consecutive-disagreement filter for one raw pin.
// The level toggles only after N back-to-back samples that differ from it.
module debounce_filter
    import lighting_pkg::*;
#(
    parameter int unsigned N = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CW = cnt_width(N);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= 1'b0;
            if (s2 != level) begin
                // Reaching N on this edge means the incremented count hits N.
                if (cnt == CW'(N - 1)) begin
                    level <= ~level;
                    cnt   <= '0;
                    rise  <= ~level;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Conditions the push button and PIR pins into clean levels and event pulses.
// Also detects a long button press, firing once per press.
module input_conditioner
    import lighting_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned PIR_FILTER_CYCLES = PIR_FILTER_CYCLES_DEF,
    parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input_conditioner_if.slave    bus
);

    localparam int unsigned HW = cnt_width(LONG_PRESS_CYCLES);

    logic          btn_level;
    logic          btn_press;
    logic          motion;
    logic          motion_rise;
    logic          btn_long;
    logic [HW-1:0] hold;

    debounce_filter #(.N(DEBOUNCE_CYCLES)) u_btn_filter (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.push_button),
        .level (btn_level),
        .rise  (btn_press)
    );

    debounce_filter #(.N(PIR_FILTER_CYCLES)) u_pir_filter (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.infravermelho),
        .level (motion),
        .rise  (motion_rise)
    );

    // Hold counter saturates at the threshold so the pulse cannot re-fire
    // until the level drops and clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold     <= '0;
            btn_long <= 1'b0;
        end else begin
            btn_long <= 1'b0;
            if (btn_level) begin
                if (hold != HW'(LONG_PRESS_CYCLES)) begin
                    hold <= hold + HW'(1);
                    if (hold == HW'(LONG_PRESS_CYCLES - 1)) begin
                        btn_long <= 1'b1;
                    end
                end
            end else begin
                hold <= '0;
            end
        end
    end

    assign bus.btn_level   = btn_level;
    assign bus.btn_press   = btn_press;
    assign bus.btn_long    = btn_long;
    assign bus.motion      = motion;
    assign bus.motion_rise = motion_rise;

endmodule
